// File: rtl/addsub_flag_unit.sv
`default_nettype none
// ============================================================================
// Module      : addsub_flag_unit
// Description : One-stage registered add/subtract unit. It produces
//               carry/overflow/zero/negative flags, optional saturation and
//               sticky overflow tracking.
// Revision    : 1.0 - initial release
// ============================================================================
module addsub_flag_unit #(
    parameter int WIDTH = 8,
    parameter int CNT_W = 8
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             op,
    input  logic             signed_mode,
    input  logic             sat_en,
    input  logic             clr_sticky,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] result,
    output logic             carry,
    output logic             overflow,
    output logic             zero,
    output logic             negative,
    output logic             ovf_sticky,
    output logic [CNT_W-1:0] ovf_count
);

    logic [WIDTH-1:0] b_eff;
    logic [WIDTH:0]   sum;
    logic [WIDTH-1:0] raw;
    logic             co;
    logic             vs;
    logic             vu;
    logic             ovf;
    logic [WIDTH-1:0] sat_val;
    logic [WIDTH-1:0] final_res;
    logic             accept;
    logic             ovf_event;

    logic             out_valid_d, out_valid_q;
    logic [WIDTH-1:0] result_d, result_q;
    logic             carry_d, carry_q;
    logic             overflow_d, overflow_q;
    logic             zero_d, zero_q;
    logic             negative_d, negative_q;
    logic             sticky_d, sticky_q;
    logic [CNT_W-1:0] count_d, count_q;
    logic [CNT_W-1:0] count_base;

    // Subtraction is a + ~b + 1, so op doubles as the carry-in.
    always_comb begin
        b_eff = op ? ~b : b;
        sum   = {1'b0, a} + {1'b0, b_eff} + {{WIDTH{1'b0}}, op};
        raw   = sum[WIDTH-1:0];
        co    = sum[WIDTH];
        vs    = (a[WIDTH-1] == b_eff[WIDTH-1]) && (raw[WIDTH-1] != a[WIDTH-1]);
        vu    = op ? !co : co;
        ovf   = signed_mode ? vs : vu;

        if (signed_mode) begin
            sat_val = a[WIDTH-1] ? {1'b1, {(WIDTH-1){1'b0}}} : {1'b0, {(WIDTH-1){1'b1}}};
        end else begin
            sat_val = op ? {WIDTH{1'b0}} : {WIDTH{1'b1}};
        end
        final_res = (sat_en && ovf) ? sat_val : raw;
    end

    assign in_ready  = !out_valid_q || out_ready;
    assign accept    = in_valid && in_ready;
    assign ovf_event = accept && ovf;

    always_comb begin
        out_valid_d = out_valid_q;
        result_d    = result_q;
        carry_d     = carry_q;
        overflow_d  = overflow_q;
        zero_d      = zero_q;
        negative_d  = negative_q;
        if (accept) begin
            out_valid_d = 1'b1;
            result_d    = final_res;
            carry_d     = co;
            overflow_d  = ovf;
            zero_d      = (final_res == {WIDTH{1'b0}});
            negative_d  = final_res[WIDTH-1];
        end else if (out_ready) begin
            out_valid_d = 1'b0;
        end
    end

    // A clear and an overflowing accept on the same edge leave exactly one event recorded.
    always_comb begin
        count_base = clr_sticky ? {CNT_W{1'b0}} : count_q;
        sticky_d   = (clr_sticky ? 1'b0 : sticky_q) | ovf_event;
        count_d    = count_base;
        if (ovf_event && (count_base != {CNT_W{1'b1}})) begin
            count_d = count_base + {{(CNT_W-1){1'b0}}, 1'b1};
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            out_valid_q <= 1'b0;
            result_q    <= {WIDTH{1'b0}};
            carry_q     <= 1'b0;
            overflow_q  <= 1'b0;
            zero_q      <= 1'b0;
            negative_q  <= 1'b0;
            sticky_q    <= 1'b0;
            count_q     <= {CNT_W{1'b0}};
        end else begin
            out_valid_q <= out_valid_d;
            result_q    <= result_d;
            carry_q     <= carry_d;
            overflow_q  <= overflow_d;
            zero_q      <= zero_d;
            negative_q  <= negative_d;
            sticky_q    <= sticky_d;
            count_q     <= count_d;
        end
    end

    assign out_valid  = out_valid_q;
    assign result     = result_q;
    assign carry      = carry_q;
    assign overflow   = overflow_q;
    assign zero       = zero_q;
    assign negative   = negative_q;
    assign ovf_sticky = sticky_q;
    assign ovf_count  = count_q;

endmodule
`default_nettype wire

// File: tb/tb_addsub_flag_unit.sv
`default_nettype none
// ============================================================================
// Module      : tb_addsub_flag_unit
// Description : Directed-vector bench for addsub_flag_unit (WIDTH=8, CNT_W=2).
// Revision    : 1.0 - initial release
// ============================================================================
module tb_addsub_flag_unit;

    localparam int WIDTH = 8;
    localparam int CNT_W = 2;

    logic             clk = 1'b0;
    logic             rst_n = 1'b0;
    logic             in_valid = 1'b0;
    logic             in_ready;
    logic [WIDTH-1:0] a = '0;
    logic [WIDTH-1:0] b = '0;
    logic             op = 1'b0;
    logic             signed_mode = 1'b0;
    logic             sat_en = 1'b0;
    logic             clr_sticky = 1'b0;
    logic             out_valid;
    logic             out_ready = 1'b1;
    logic [WIDTH-1:0] result;
    logic             carry, overflow, zero, negative;
    logic             ovf_sticky;
    logic [CNT_W-1:0] ovf_count;

    int n_cmp  = 0;
    int n_fail = 0;

    always #5 clk = ~clk;

    addsub_flag_unit #(.WIDTH(WIDTH), .CNT_W(CNT_W)) dut (
        .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready),
        .a(a), .b(b), .op(op), .signed_mode(signed_mode), .sat_en(sat_en),
        .clr_sticky(clr_sticky), .out_valid(out_valid), .out_ready(out_ready),
        .result(result), .carry(carry), .overflow(overflow), .zero(zero),
        .negative(negative), .ovf_sticky(ovf_sticky), .ovf_count(ovf_count)
    );

    typedef struct {
        logic [7:0] a;
        logic [7:0] b;
        logic       op;
        logic       sm;
        logic       sat;
        logic [7:0] res;
        logic       c;
        logic       v;
        logic       z;
        logic       n;
    } vec_t;

    vec_t vecs[14];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
        end
    endtask

    task automatic chk_outputs_clear(input string tag);
        chk({tag, " out_valid"}, 32'(out_valid), 32'd0);
        chk({tag, " in_ready"},  32'(in_ready),  32'd1);
        chk({tag, " result"},    32'(result),    32'd0);
        chk({tag, " flags"},     32'({carry, overflow, zero, negative}), 32'd0);
        chk({tag, " sticky"},    32'(ovf_sticky), 32'd0);
        chk({tag, " count"},     32'(ovf_count),  32'd0);
    endtask

    task automatic drive(input logic [7:0] ia, input logic [7:0] ib, input logic iop,
                         input logic ism, input logic isat);
        a = ia; b = ib; op = iop; signed_mode = ism; sat_en = isat; in_valid = 1'b1;
    endtask

    task automatic send(input logic [7:0] ia, input logic [7:0] ib, input logic iop,
                        input logic ism, input logic isat);
        @(negedge clk);
        drive(ia, ib, iop, ism, isat);
        @(posedge clk);
        #1;
        in_valid = 1'b0;
    endtask

    task automatic do_reset();
        @(negedge clk);
        rst_n = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;
    endtask

    initial begin
        //            a      b    op  sm  sat  res    c  v  z  n
        vecs[0]  = '{8'h7F, 8'h01, 0, 1, 0, 8'h80, 0, 1, 0, 1};
        vecs[1]  = '{8'h7F, 8'h01, 0, 1, 1, 8'h7F, 0, 1, 0, 0};
        vecs[2]  = '{8'hFF, 8'h01, 0, 0, 0, 8'h00, 1, 1, 1, 0};
        vecs[3]  = '{8'hFF, 8'h01, 0, 0, 1, 8'hFF, 1, 1, 0, 1};
        vecs[4]  = '{8'h00, 8'h01, 1, 0, 1, 8'h00, 0, 1, 1, 0};
        vecs[5]  = '{8'h80, 8'h01, 1, 1, 1, 8'h80, 1, 1, 0, 1};
        vecs[6]  = '{8'h05, 8'h03, 1, 0, 0, 8'h02, 1, 0, 0, 0};
        vecs[7]  = '{8'h80, 8'h80, 0, 1, 1, 8'h80, 1, 1, 0, 1};
        vecs[8]  = '{8'h80, 8'h80, 0, 1, 0, 8'h00, 1, 1, 1, 0};
        vecs[9]  = '{8'hFF, 8'h01, 0, 1, 1, 8'h00, 1, 0, 1, 0};
        vecs[10] = '{8'h03, 8'h03, 1, 0, 1, 8'h00, 1, 0, 1, 0};
        vecs[11] = '{8'h7F, 8'hFF, 1, 1, 1, 8'h7F, 0, 1, 0, 0};
        vecs[12] = '{8'h12, 8'h34, 0, 0, 1, 8'h46, 0, 0, 0, 0};
        vecs[13] = '{8'h00, 8'h01, 1, 1, 1, 8'hFF, 0, 0, 0, 1};

        // Reset state, while rst_n is still low
        #2;
        chk_outputs_clear("reset");
        @(negedge clk);
        rst_n = 1'b1;

        // Table-driven vectors
        for (int i = 0; i < 14; i++) begin
            send(vecs[i].a, vecs[i].b, vecs[i].op, vecs[i].sm, vecs[i].sat);
            chk($sformatf("v%0d out_valid", i), 32'(out_valid), 32'd1);
            chk($sformatf("v%0d result", i),    32'(result),    32'(vecs[i].res));
            chk($sformatf("v%0d flags cvzn", i), 32'({carry, overflow, zero, negative}),
                32'({vecs[i].c, vecs[i].v, vecs[i].z, vecs[i].n}));
        end
        @(posedge clk);
        #1;
        chk("idle out_valid drop", 32'(out_valid), 32'd0);
        chk("sticky after table", 32'(ovf_sticky), 32'd1);
        chk("count sat after table", 32'(ovf_count), 32'd3);

        // Backpressure: hold one result while a second bundle waits
        out_ready = 1'b0;
        send(8'h12, 8'h34, 0, 0, 0);
        chk("bp first out_valid", 32'(out_valid), 32'd1);
        @(negedge clk);
        drive(8'h00, 8'h01, 0, 0, 0);
        for (int i = 0; i < 3; i++) begin
            @(posedge clk);
            #1;
            chk($sformatf("bp hold%0d in_ready", i), 32'(in_ready), 32'd0);
            chk($sformatf("bp hold%0d out_valid", i), 32'(out_valid), 32'd1);
            chk($sformatf("bp hold%0d result", i), 32'(result), 32'h46);
        end
        @(negedge clk);
        out_ready = 1'b1;
        #1;
        chk("bp release in_ready", 32'(in_ready), 32'd1);
        @(posedge clk);
        #1;
        in_valid = 1'b0;
        chk("bp second out_valid", 32'(out_valid), 32'd1);
        chk("bp second result", 32'(result), 32'h01);
        @(posedge clk);
        #1;
        chk("bp drain out_valid", 32'(out_valid), 32'd0);

        // Overflow counter saturation and same-edge clear
        do_reset();
        for (int i = 1; i <= 5; i++) begin
            send(8'h7F, 8'h01, 0, 1, 0);
            chk($sformatf("cnt step%0d", i), 32'(ovf_count), 32'((i > 3) ? 3 : i));
        end
        chk("cnt sticky", 32'(ovf_sticky), 32'd1);
        @(negedge clk);
        clr_sticky = 1'b1;
        drive(8'h7F, 8'h01, 0, 1, 0);
        @(posedge clk);
        #1;
        in_valid = 1'b0;
        chk("clr+ovf sticky", 32'(ovf_sticky), 32'd1);
        chk("clr+ovf count", 32'(ovf_count), 32'd1);
        @(posedge clk);
        #1;
        clr_sticky = 1'b0;
        chk("clr sticky", 32'(ovf_sticky), 32'd0);
        chk("clr count", 32'(ovf_count), 32'd0);
        chk("clr keeps result", 32'(result), 32'h80);
        chk("clr keeps flags", 32'({carry, overflow, zero, negative}), 32'b0101);

        // Asynchronous reset in mid-cycle while holding a result
        out_ready = 1'b0;
        send(8'hFF, 8'h01, 0, 0, 0);
        chk("pre-reset out_valid", 32'(out_valid), 32'd1);
        #2;
        rst_n = 1'b0;
        #1;
        chk_outputs_clear("async reset");
        @(negedge clk);
        rst_n = 1'b1;
        out_ready = 1'b1;
        @(posedge clk);
        #1;
        chk("post-reset out_valid", 32'(out_valid), 32'd0);
        chk("post-reset in_ready", 32'(in_ready), 32'd1);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/addsub_flag_unit.md
ADDSUB_FLAG_UNIT -- requirements
Module: addsub_flag_unit

Interface
REQ-001 The block SHALL have a single clock and an asynchronous, active-low reset.
REQ-002 Parameter WIDTH SHALL default to 8 and set the operand and result width; the legal range is 2 or greater.
REQ-003 Parameter CNT_W SHALL default to 8 and set the overflow event counter width; the legal range is 1 or greater.
REQ-004 clk  in  1  rising-edge clock.
REQ-005 rst_n  in  1  asynchronous active-low reset.
REQ-006 in_valid  in  1  operand bundle valid.
REQ-007 in_ready  out  1  block can accept a bundle.
REQ-008 a, b  in  WIDTH each  operands.
REQ-009 op  in  1  operation select: 0 = a+b, 1 = a-b.
REQ-010 signed_mode  in  1  operand interpretation: 1 = two's complement, 0 = unsigned.
REQ-011 sat_en  in  1  1 = saturate the result on overflow.
REQ-012 clr_sticky  in  1  clears ovf_sticky and ovf_count.
REQ-013 out_valid  out  1  result bundle valid.
REQ-014 out_ready  in  1  downstream accepts the result.
REQ-015 result  out  WIDTH  final result, after any saturation.
REQ-016 carry, overflow, zero, negative  out  1 each  flags for the held result.
REQ-017 ovf_sticky  out  1  set once any accepted bundle overflows.
REQ-018 ovf_count  out  CNT_W  count of overflowing bundles.

Function
REQ-019 A bundle SHALL be accepted on a rising edge when in_valid=1 and in_ready=1.
REQ-020 in_ready SHALL equal (!out_valid || out_ready).
REQ-021 Latency SHALL be one cycle: an accepted bundle's result is registered and out_valid is asserted on the same edge.
REQ-022 With out_valid=1 and out_ready=0, all output fields SHALL hold stable.
REQ-023 out_valid SHALL clear on a transfer edge unless a new bundle is accepted on that same edge.
REQ-024 Raw sum SHALL be the (WIDTH+1)-bit value a + (op ? ~b : b) + op. raw = low WIDTH bits; co = bit WIDTH.
REQ-025 carry SHALL equal co in both modes; for subtraction, 1 means no borrow.
REQ-026 Signed overflow vs SHALL be set when the MSB of a equals the MSB of (op ? ~b : b) and the MSB of raw differs from the MSB of a.
REQ-027 Unsigned overflow vu SHALL equal co when op=0, and !co when op=1.
REQ-028 The overflow output SHALL equal vs when signed_mode=1, and vu when signed_mode=0.
REQ-029 When sat_en=0, result SHALL equal raw.
REQ-030 When sat_en=1 and overflow=1 in signed mode, result SHALL be the maximum positive value 0 followed by ones if a's MSB is 0, else the minimum value 1 followed by zeros.
REQ-031 When sat_en=1 and overflow=1 in unsigned mode, result SHALL be all ones for add and all zeros for subtract.
REQ-032 zero and negative SHALL be computed from the final result: negative is its MSB regardless of mode; zero is 1 when the result equals 0.
REQ-033 ovf_sticky SHALL set on the edge that accepts a bundle whose overflow is 1.
REQ-034 ovf_count SHALL increment on the same edge as REQ-033 and saturate at all ones; it SHALL never wrap.
REQ-035 clr_sticky=1 SHALL clear ovf_sticky and ovf_count on that edge. If an overflowing bundle is accepted on the same edge, ovf_sticky SHALL become 1 and ovf_count SHALL become 1.
REQ-036 clr_sticky SHALL NOT affect out_valid, result or the per-result flags.

Reset
REQ-037 rst_n=0 SHALL immediately clear out_valid, result, all four flags, ovf_sticky and ovf_count, independent of clk.
REQ-038 Reset asserted with a result held SHALL discard that result; in_ready SHALL read 1 during and after reset.
REQ-039 Reset deassertion SHALL take effect on the first rising edge at which rst_n is sampled 1.

Verification
REQ-040 WIDTH=8, signed, add, a=0x7F, b=0x01, sat_en=0 -> result=0x80, overflow=1, carry=0, negative=1, zero=0; with sat_en=1 -> result=0x7F, negative=0.
REQ-041 Unsigned, add, a=0xFF, b=0x01 -> sat_en=0: result=0x00, carry=1, overflow=1, zero=1; sat_en=1: result=0xFF, zero=0.
REQ-042 Unsigned, sub, a=0x00, b=0x01, sat_en=1 -> result=0x00, carry=0, overflow=1, zero=1; signed, sub, a=0x80, b=0x01, sat_en=1 -> result=0x80, overflow=1.
REQ-043 Hold out_ready=0 for 3 cycles with in_valid=1 -> in_ready=0 and result stable throughout; release out_ready -> the next bundle is accepted on the same edge and out_valid stays 1.
REQ-044 CNT_W=2: five overflowing bundles -> ovf_count=3; then clr_sticky=1 on the same edge as an overflowing accept -> ovf_sticky=1, ovf_count=1.
REQ-045 Drop rst_n mid-cycle while out_valid=1 -> all outputs clear immediately, before the next clock edge.
